// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory data-port arbiter.
// Request beats are packed structs so one bus carries a whole beat.
package mem_arb_pkg;

   localparam int XLEN = 32;

   typedef struct packed {
      logic            we;
      logic [3:0]      mask;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic            lock;
   } mem_req_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle of the data-port arbiter.
// The slave side is the arbiter; the master side is requesters plus memory.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   mem_req_t [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [NUM_REQ-1:0][XLEN-1:0]  rsp_rdata;

   logic                          mem_we;
   logic [3:0]                    mem_mask;
   logic [XLEN-1:0]               mem_addr;
   logic [XLEN-1:0]               mem_data_in;
   logic [XLEN-1:0]               mem_data_out;

   modport master (
      output req_valid, req, mem_data_out,
      input  req_ready, rsp_valid, rsp_rdata,
      input  mem_we, mem_mask, mem_addr, mem_data_in
   );

   modport slave (
      input  req_valid, req, mem_data_out,
      output req_ready, rsp_valid, rsp_rdata,
      output mem_we, mem_mask, mem_addr, mem_data_in
   );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Rotating-priority picker: first valid index after ptr, wrapping; pure combinational.
// No state and no backpressure; the caller decides whether the pick is used.
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               any
);

   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      any   = 1'b0;
      idx   = '0;
      // Scan ptr+1 .. ptr+NUM_REQ so the last winner has lowest priority.
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PW'((int'(ptr) + k) % NUM_REQ);
         if (!any && valid[idx]) begin
            grant[idx] = 1'b1;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the unified memory data port with bounded lock; grant is same-cycle,
// response exactly one cycle after each grant; responses cannot be stalled by requesters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int MAX_LOCK = 16
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_LOCK + 1);

   arb_state_e         state;
   arb_state_e         state_nxt;
   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      owner;
   logic [CW-1:0]      lock_cnt;
   logic               lock_expired;

   logic [NUM_REQ-1:0] rr_grant;
   logic               rr_any;
   logic [NUM_REQ-1:0] grant;
   logic               gnt_any;
   logic [PW-1:0]      gnt_idx;
   mem_req_t           gnt_req;

   logic               rsp_pend;
   logic               rsp_is_read;
   logic [PW-1:0]      rsp_owner;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_rr_pick (
      .valid (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (rr_grant),
      .any   (rr_any)
   );

   assign lock_expired = (state == LOCKED) && (lock_cnt == CW'(MAX_LOCK));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (gnt_any && gnt_req.lock) begin
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (lock_expired || (gnt_any && !gnt_req.lock)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: grant vector and the beat steered onto the memory port
   always_comb begin
      grant   = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (!rst) begin
         if (state == IDLE) begin
            grant   = rr_grant;
            gnt_any = rr_any;
         end else if (bus.req_valid[owner] && !lock_expired) begin
            grant[owner] = 1'b1;
            gnt_any      = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            gnt_idx = PW'(i);
         end
      end
      gnt_req = gnt_any ? bus.req[gnt_idx] : '0;
   end

   assign bus.req_ready   = grant;
   assign bus.mem_we      = gnt_req.we;
   assign bus.mem_mask    = gnt_req.mask;
   assign bus.mem_addr    = gnt_req.addr;
   assign bus.mem_data_in = gnt_req.wdata;

   // Pointer, lock bookkeeping and the one-deep response pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr      <= PW'(NUM_REQ - 1);
         owner       <= '0;
         lock_cnt    <= '0;
         rsp_pend    <= 1'b0;
         rsp_is_read <= 1'b0;
         rsp_owner   <= '0;
      end else begin
         rsp_pend    <= gnt_any;
         rsp_is_read <= gnt_any && !gnt_req.we;
         rsp_owner   <= gnt_idx;

         // An expired lock hands priority to everyone after the owner.
         if (gnt_any) begin
            rr_ptr <= gnt_idx;
         end else if (lock_expired) begin
            rr_ptr <= owner;
         end

         if (state == IDLE) begin
            if (gnt_any && gnt_req.lock) begin
               owner    <= gnt_idx;
               lock_cnt <= CW'(1);
            end
         end else if (state_nxt == IDLE) begin
            lock_cnt <= '0;
         end else begin
            lock_cnt <= lock_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      bus.rsp_valid = '0;
      bus.rsp_rdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!rst && rsp_pend && (rsp_owner == PW'(i))) begin
            bus.rsp_valid[i] = 1'b1;
            bus.rsp_rdata[i] = rsp_is_read ? bus.mem_data_out : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ($onehot0(grant));
      end
   end

endmodule
